color_bank_nch: RTL and testbench

- Parametrised successor to the fixed 4-channel color processor: holds N_CH per-channel RGB colors of 3*COMP_W bits each.
- Colors are loaded and read back over the shared nibble register bus (address/data/valid/ack, data_out/data_out_valid), which is OR-combined with the other bus slaves.
- Button pulses cycle a channel through a preset palette or swap the displayed channel mapping horizontally/vertically.
- Outputs feed the seven-segment interface and pixel path.

---
 rtl/color_bank_nch.sv | 152 +++++++++++++++
 tb/tb_color_bank_nch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/color_bank_nch.sv
// color_bank_nch: N_CH-channel RGB color bank with nibble-bus load/readback, palette stepping and swap mapping.
// Optional readback engine enabled by COLOR_BANK_READBACK_EN.
module color_bank_nch #(
  parameter int N_CH = 4,
  parameter int COMP_W = 8,
  parameter logic [3:0] ADDR_WR = 4'h6,
  parameter logic [3:0] ADDR_RD = 4'h7
) (
  input  logic clk,
  input  logic rst,
  input  logic swap_h,
  input  logic swap_v,
  input  logic color_next,
  input  logic [$clog2(N_CH)-1:0] channel,
  input  logic [3:0] address,
  input  logic [3:0] data,
  input  logic valid,
  output logic ack,
  output logic [3:0] data_out,
  output logic data_out_valid,
  output logic busy,
  output logic map_h,
  output logic map_v,
  output logic [N_CH*3*COMP_W-1:0] ch_flat,
  output logic [N_CH*3*COMP_W-1:0] rgb_flat
);
  localparam int CH_W = $clog2(N_CH);
  localparam int CW = 3 * COMP_W;
  localparam int NIB = CW / 4;
  localparam int PW = $clog2(NIB + 1);
  localparam logic [0:0] W_IDLE = 1'b0, W_LOAD = 1'b1;

  function automatic logic [CW-1:0] pal(input logic [2:0] k);
    return {{COMP_W{k inside {3'd1, 3'd4, 3'd6, 3'd7}}},
            {COMP_W{k inside {3'd2, 3'd4, 3'd5, 3'd7}}},
            {COMP_W{k inside {3'd3, 3'd5, 3'd6, 3'd7}}}};
  endfunction

  logic [N_CH-1:0][CW-1:0] ch_q, ch_d, rgb_q, rgb_d;
  logic [N_CH-1:0][2:0] pal_q, pal_d;
  logic [CW-1:0] stage_q, stage_d, shifted;
  logic [PW-1:0] nib_q, nib_d;
  logic [0:0] wst_q, wst_d;
  logic [CH_W-1:0] lch_q, lch_d, mask;
  logic map_h_q, map_h_d, map_v_q, map_v_d, ack_q, ack_d;
  logic wr, abort, wr_ok, last, commit, rd_ok, rbusy;

  assign shifted = {stage_q[CW-5:0], data};
  assign busy = (wst_q == W_LOAD) || rbusy;
  assign ack = ack_q;
  assign map_h = map_h_q;
  assign map_v = map_v_q;
  assign ch_flat = ch_q;
  assign rgb_flat = rgb_q;

  always_comb begin
    wr = valid && address == ADDR_WR;
    abort = wst_q == W_LOAD && channel != lch_q;
    wr_ok = wr && !abort && !rbusy;
    last = nib_q == PW'(NIB - 1);
    commit = wr_ok && last;
    mask = CH_W'(map_h_q) ^ (CH_W'(map_v_q) << (CH_W - 1));
    stage_d = wr_ok ? shifted : stage_q;
    nib_d = abort ? '0 : wr_ok ? (last ? '0 : nib_q + PW'(1)) : nib_q;
    wst_d = abort ? W_IDLE : wr_ok ? (last ? W_IDLE : W_LOAD) : wst_q;
    lch_d = wr_ok ? channel : lch_q;
    ack_d = wr_ok || rd_ok;
    map_h_d = map_h_q ^ swap_h;
    map_v_d = map_v_q ^ swap_v;
    ch_d = ch_q;
    pal_d = pal_q;
    // a commit outranks a palette step on the same channel cycle
    if (commit) ch_d[channel] = shifted;
    else if (color_next && !busy) begin
      pal_d[channel] = pal_q[channel] + 3'd1;
      ch_d[channel] = pal(pal_q[channel] + 3'd1);
    end
    for (int i = 0; i < N_CH; i++) rgb_d[i] = ch_q[CH_W'(i) ^ mask];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_q[i] <= pal(3'((i + 1) % 8));
        rgb_q[i] <= pal(3'((i + 1) % 8));
        pal_q[i] <= 3'((i + 1) % 8);
      end
      stage_q <= '0;
      nib_q <= '0;
      wst_q <= W_IDLE;
      lch_q <= '0;
      map_h_q <= 1'b0;
      map_v_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ch_q <= ch_d;
      rgb_q <= rgb_d;
      pal_q <= pal_d;
      stage_q <= stage_d;
      nib_q <= nib_d;
      wst_q <= wst_d;
      lch_q <= lch_d;
      map_h_q <= map_h_d;
      map_v_q <= map_v_d;
      ack_q <= ack_d;
    end
  end

`ifdef COLOR_BANK_READBACK_EN
  localparam logic [0:0] R_IDLE = 1'b0, R_STREAM = 1'b1;
  logic [0:0] rs_q, rs_d;
  logic [CW-1:0] cap_q, cap_d;
  logic [PW-1:0] rcnt_q, rcnt_d;
  logic [3:0] dout_q, dout_d;
  logic dval_q, dval_d;

  assign rbusy = rs_q == R_STREAM || dval_q;
  assign data_out = dout_q;
  assign data_out_valid = dval_q;

  always_comb begin
    rd_ok = valid && address == ADDR_RD && !busy;
    rs_d = rd_ok ? R_STREAM : (rs_q == R_STREAM && rcnt_q == PW'(1)) ? R_IDLE : rs_q;
    cap_d = rd_ok ? {ch_q[channel][CW-5:0], 4'h0} : {cap_q[CW-5:0], 4'h0};
    rcnt_d = rd_ok ? PW'(NIB - 1) : rs_q == R_STREAM ? rcnt_q - PW'(1) : rcnt_q;
    dval_d = rd_ok || rs_q == R_STREAM;
    dout_d = rd_ok ? ch_q[channel][CW-1-:4] : rs_q == R_STREAM ? cap_q[CW-1-:4] : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q <= R_IDLE;
      cap_q <= '0;
      rcnt_q <= '0;
      dout_q <= 4'h0;
      dval_q <= 1'b0;
    end else begin
      rs_q <= rs_d;
      cap_q <= cap_d;
      rcnt_q <= rcnt_d;
      dout_q <= dout_d;
      dval_q <= dval_d;
    end
  end
`else
  // no readback engine: ADDR_RD decodes to nothing and is never acked
  assign rd_ok = 1'b0 && address == ADDR_RD;
  assign rbusy = 1'b0;
  assign data_out = 4'h0;
  assign data_out_valid = 1'b0;
`endif
endmodule

// File: tb/tb_color_bank_nch.sv
// tb_color_bank_nch: directed self-checking bench for color_bank_nch (N_CH=4, COMP_W=8).
module tb_color_bank_nch;
  logic clk = 1'b0, rst = 1'b1, swap_h = 1'b0, swap_v = 1'b0, color_next = 1'b0, valid = 1'b0;
  logic [1:0] channel = 2'd0;
  logic [3:0] address = 4'h0, data = 4'h0, data_out;
  logic ack, data_out_valid, busy, map_h, map_v;
  logic [95:0] ch_flat, rgb_flat;
  int chk_cnt = 0, pass_cnt = 0;
  localparam logic [23:0] PAL [8] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                                      24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFFFFFF};
  localparam logic [3:0] WNIB [6] = '{4'hF, 4'h0, 4'h8, 4'h0, 4'h4, 4'h2};

  color_bank_nch dut (
    .clk(clk), .rst(rst), .swap_h(swap_h), .swap_v(swap_v), .color_next(color_next),
    .channel(channel), .address(address), .data(data), .valid(valid), .ack(ack),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
    .map_h(map_h), .map_v(map_v), .ch_flat(ch_flat), .rgb_flat(rgb_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [3:0] a, input logic [3:0] d);
    valid = 1'b1;
    address = a;
    data = d;
    step();
    valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ch", ch_flat, {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000});
    chk("rst_rgb", rgb_flat, {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000});
    chk("rst_map", {map_h, map_v}, 2'b00);
    chk("rst_bus", {ack, busy, data_out_valid, data_out}, 7'h0);

    channel = 2'd2;
    for (int k = 0; k < 6; k++) begin
      bus(4'h6, WNIB[k]);
      chk($sformatf("wr_ack%0d", k), ack, 1'b1);
      chk($sformatf("wr_ch2_%0d", k), ch_flat[48 +: 24], k < 5 ? 24'h0000FF : 24'hF08042);
      chk($sformatf("wr_busy%0d", k), busy, k < 5);
      step();
      chk($sformatf("wr_ackfall%0d", k), ack, 1'b0);
      step();
    end
    chk("wr_rgb2", rgb_flat[48 +: 24], 24'hF08042);

    channel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      bus(4'h6, 4'hA);
      step();
    end
    chk("abort_busy_pre", busy, 1'b1);
    channel = 2'd3;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_ack", ack, 1'b0);
    chk("abort_ch13", {ch_flat[72 +: 24], ch_flat[24 +: 24]}, {24'hFFFF00, 24'h00FF00});
    for (int k = 0; k < 6; k++) begin
      bus(4'h6, 4'(k + 1));
      chk($sformatf("wr3_ack%0d", k), ack, 1'b1);
      step();
    end
    chk("wr3_ch3", ch_flat[72 +: 24], 24'h123456);

    swap_h = 1'b1;
    step();
    swap_h = 1'b0;
    chk("swh_map", {map_h, map_v}, 2'b10);
    step();
    chk("swh_rgb0", rgb_flat[0 +: 24], 24'h00FF00);
    swap_v = 1'b1;
    step();
    swap_v = 1'b0;
    step();
    chk("swv_rgb01", rgb_flat[0 +: 48], {24'hF08042, 24'h123456});
    swap_h = 1'b1;
    swap_v = 1'b1;
    step();
    swap_h = 1'b0;
    swap_v = 1'b0;
    chk("swhv_map", {map_h, map_v}, 2'b00);
    step();
    chk("swhv_rgb", rgb_flat, {24'h123456, 24'hF08042, 24'h00FF00, 24'hFF0000});

    channel = 2'd0;
    for (int k = 0; k < 8; k++) begin
      color_next = 1'b1;
      step();
      color_next = 1'b0;
      chk($sformatf("cn%0d", k), ch_flat[0 +: 24], PAL[(k + 2) % 8]);
    end
    for (int k = 0; k < 5; k++) begin
      bus(4'h6, k == 4 ? 4'h1 : 4'h0);
      step();
    end
    color_next = 1'b1;
    bus(4'h6, 4'h1);
    color_next = 1'b0;
    chk("commit_wins", ch_flat[0 +: 24], 24'h000011);
    chk("commit_ack", ack, 1'b1);
    step();
    color_next = 1'b1;
    step();
    color_next = 1'b0;
    chk("cn_after_commit", ch_flat[0 +: 24], 24'h00FF00);

    channel = 2'd2;
`ifdef COLOR_BANK_READBACK_EN
    bus(4'h7, 4'h0);
    chk("rd_ack", ack, 1'b1);
    chk("rd_n0", {data_out_valid, data_out}, {1'b1, 4'hF});
    for (int k = 1; k < 6; k++) begin
      if (k == 2) bus(4'h6, 4'h9);
      else step();
      chk($sformatf("rd_n%0d", k), {data_out_valid, data_out, busy, ack}, {1'b1, WNIB[k], 1'b1, 1'b0});
    end
    step();
    chk("rd_end", {data_out_valid, data_out, busy}, 6'h0);
    chk("rd_ch2", ch_flat[48 +: 24], 24'hF08042);
`else
    bus(4'h7, 4'h0);
    chk("rd_noack", ack, 1'b0);
    step();
    chk("rd_nodval", {data_out_valid, data_out, busy}, 6'h0);
`endif
    bus(4'h3, 4'h5);
    chk("unk_addr", ack, 1'b0);

    bus(4'h6, 4'h7);
    bus(4'h6, 4'h7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {busy, ack, map_h, map_v}, 4'h0);
    chk("midrst_ch", ch_flat, {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000});

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
